// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch PC register with JR/branch/jump redirect, stall buffering and misaligned-target trap
//   clk, rst            : clock, asynchronous active-high reset
//   stall               : hold pc; a redirect seen while stalled is buffered
//   jr_control/jr_target, branch_taken/branch_target, jump/jump_index : redirect requests (priority in that order)
//   pc, pc_plus4        : registered fetch PC and its combinational successor
//   flush               : one-cycle IF/ID flush after each redirect
//   pending             : a buffered redirect awaits stall release
//   addr_error, epc     : sticky misaligned-target flag and last offending target
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        jr_control,
    input  logic [31:0] jr_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        flush,
    output logic        pending,
    output logic        addr_error,
    output logic [31:0] epc
);
    logic [31:0] pc_q, pc_d, epc_q, epc_d, tgt_q, tgt_d, t;
    logic        flush_q, flush_d, pending_q, pending_d, addr_error_q, addr_error_d;
    logic        r, trap;
    always_comb begin
        t = jr_control ? jr_target : branch_taken ? branch_target : {pc_q[31:28], jump_index, 2'b00};
        r = jr_control | branch_taken | jump;
        trap = r && (t[1:0] != 2'b00);
        pc_d = pc_q;
        epc_d = epc_q;
        tgt_d = tgt_q;
        flush_d = 1'b0;
        pending_d = pending_q;
        addr_error_d = addr_error_q;
        // a misaligned target traps even while stalled
        if (trap) begin
            pc_d = EXC_VECTOR;
            epc_d = t;
            addr_error_d = 1'b1;
            flush_d = 1'b1;
            pending_d = 1'b0;
        end else if (!stall) begin
            pc_d = r ? t : pending_q ? tgt_q : pc_q + 32'd4;
            flush_d = r | pending_q;
            pending_d = 1'b0;
        end else if (r) begin
            pending_d = 1'b1;
            tgt_d = t;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
            epc_q <= '0;
            tgt_q <= '0;
            flush_q <= 1'b0;
            pending_q <= 1'b0;
            addr_error_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            epc_q <= epc_d;
            tgt_q <= tgt_d;
            flush_q <= flush_d;
            pending_q <= pending_d;
            addr_error_q <= addr_error_d;
        end
    end
    assign pc = pc_q;
    assign pc_plus4 = pc_q + 32'd4;
    assign flush = flush_q;
    assign pending = pending_q;
    assign addr_error = addr_error_q;
    assign epc = epc_q;
endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: directed plus randomized check of pc_redirect_unit against a behavioural model
module tb_pc_redirect_unit;
    logic        clk = 1'b0, rst = 1'b1, stall = 1'b0;
    logic        jr_control = 1'b0, branch_taken = 1'b0, jump = 1'b0;
    logic [31:0] jr_target = '0, branch_target = '0;
    logic [25:0] jump_index = '0;
    logic [31:0] pc, pc_plus4, epc;
    logic        flush, pending, addr_error;
    int          n_tests = 0, n_fail = 0;
    logic [31:0] m_pc, m_epc, m_tgt;
    logic        m_flush, m_pend, m_err;

    pc_redirect_unit dut (
        .clk(clk), .rst(rst), .stall(stall),
        .jr_control(jr_control), .jr_target(jr_target),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_index(jump_index),
        .pc(pc), .pc_plus4(pc_plus4), .flush(flush), .pending(pending),
        .addr_error(addr_error), .epc(epc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_epc = '0; m_tgt = '0; m_flush = 0; m_pend = 0; m_err = 0;
    endtask

    task automatic check_all();
        check("pc", pc, m_pc);
        check("pc_plus4", pc_plus4, m_pc + 32'd4);
        check("flush", {31'b0, flush}, {31'b0, m_flush});
        check("pending", {31'b0, pending}, {31'b0, m_pend});
        check("addr_error", {31'b0, addr_error}, {31'b0, m_err});
        check("epc", epc, m_epc);
    endtask

    task automatic clear_req();
        jr_control = 0; branch_taken = 0; jump = 0;
    endtask

    // one clock: predict from the request rules, advance, then compare
    task automatic cyc();
        logic [31:0] t;
        logic        r;
        r = jr_control || branch_taken || jump;
        if (jr_control) t = jr_target;
        else if (branch_taken) t = branch_target;
        else t = (m_pc & 32'hF000_0000) + ({6'b0, jump_index} * 4);
        @(posedge clk);
        #1;
        if (r && (t % 4 != 0)) begin
            m_pc = 32'h80; m_epc = t; m_err = 1; m_flush = 1; m_pend = 0;
        end else if (!stall) begin
            if (r) begin
                m_pc = t; m_flush = 1;
            end else if (m_pend) begin
                m_pc = m_tgt; m_flush = 1;
            end else begin
                m_pc = m_pc + 4; m_flush = 0;
            end
            m_pend = 0;
        end else begin
            m_flush = 0;
            if (r) begin
                m_pend = 1; m_tgt = t;
            end
        end
        check_all();
    endtask

    task automatic do_jr(input logic [31:0] a);
        clear_req(); jr_control = 1; jr_target = a; cyc(); clear_req();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 0;
        repeat (3) cyc();
        check("pc_seq", pc, 32'hC);
        do_jr(32'h40);
        stall = 1; cyc(); stall = 0;
        check("pc_hold", pc, 32'h40);
        do_jr(32'h1000);
        check("jr_pc", pc, 32'h1000);
        check("jr_flush", {31'b0, flush}, 32'h1);
        cyc();
        check("flush_once", {31'b0, flush}, 32'h0);
        jr_control = 1; jr_target = 32'h200; branch_taken = 1; branch_target = 32'h300;
        jump = 1; jump_index = 26'h10;
        cyc(); clear_req();
        check("jr_prio", pc, 32'h200);
        stall = 1;
        branch_taken = 1; branch_target = 32'h500; cyc(); clear_req();
        cyc();
        jump = 1; jump_index = 26'h40; cyc(); clear_req();
        cyc(); cyc();
        check("stall_hold", pc, 32'h200);
        check("stall_pend", {31'b0, pending}, 32'h1);
        stall = 0; cyc();
        check("release_pc", pc, 32'h100);
        check("release_flush", {31'b0, flush}, 32'h1);
        check("release_pend", {31'b0, pending}, 32'h0);
        stall = 1; do_jr(32'h1002); stall = 0;
        check("trap_pc", pc, 32'h80);
        check("trap_epc", epc, 32'h1002);
        check("trap_err", {31'b0, addr_error}, 32'h1);
        do_jr(32'h40);
        check("err_sticky", {31'b0, addr_error}, 32'h1);
        do_jr(32'hFFFF_FFFC);
        cyc();
        check("wrap", pc, 32'h0);
        stall = 1; do_jr(32'h800);
        check("pre_rst_pend", {31'b0, pending}, 32'h1);
        #2 rst = 1;
        #1;
        model_reset();
        check("async_pc", pc, 32'h0);
        check("async_pend", {31'b0, pending}, 32'h0);
        check_all();
        @(posedge clk);
        #1 rst = 0; stall = 0;
        check_all();
        for (int i = 0; i < 3000; i++) begin
            stall = ($urandom_range(0, 9) < 4);
            jr_control = ($urandom_range(0, 9) == 0);
            branch_taken = ($urandom_range(0, 9) == 0);
            jump = ($urandom_range(0, 9) == 0);
            jr_target = $urandom & (($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            branch_target = $urandom & (($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            jump_index = 26'($urandom);
            cyc();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
